// File: rtl/clock_pkg.sv
// Shared constants, alarm channel state type and the wrap-around minute adder
// used by the alarm clock datapath.
package clock_pkg;

  localparam int HR_MAX  = 23;
  localparam int MIN_MAX = 59;
  localparam int SEC_MAX = 59;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } alarm_state_t;

  typedef struct packed {
    logic [4:0] hr;
    logic [5:0] min;
  } hm_t;

  // hr:min + n minutes, wrapping at 24 h
  function automatic hm_t add_minutes(input logic [4:0] hr, input logic [5:0] min, input int n);
    int  total;
    hm_t r;
    total = (int'(hr) * (MIN_MAX + 1) + int'(min) + n) % ((HR_MAX + 1) * (MIN_MAX + 1));
    r.hr  = 5'(total / (MIN_MAX + 1));
    r.min = 6'(total % (MIN_MAX + 1));
    return r;
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: programmed alarm time, snooze target, ring timeout counter
// and the IDLE/RINGING/SNOOZE state machine.
module alarm_channel
  import clock_pkg::*;
#(
  parameter int SNOOZE_MIN       = 5,
  parameter int RING_TIMEOUT_SEC = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_i,
  input  logic [4:0] wr_hr_i,
  input  logic [5:0] wr_min_i,
  input  logic       wr_en_i,
  input  logic       clear_i,
  input  logic       snooze_i,
  input  logic       tick_d_i,
  input  logic [4:0] hr_i,
  input  logic [5:0] min_i,
  input  logic [5:0] sec_i,
  output logic       ringing_o
);

  alarm_state_t state_q, state_d;
  logic [4:0]   al_hr_q, al_hr_d;
  logic [5:0]   al_min_q, al_min_d;
  logic         en_q, en_d;
  hm_t          tgt_q, tgt_d;
  logic [7:0]   ring_cnt_q, ring_cnt_d;
  logic         alarm_hit;
  logic         snooze_hit;

  assign alarm_hit  = en_q && tick_d_i && (hr_i == al_hr_q) && (min_i == al_min_q) && (sec_i == '0);
  assign snooze_hit = tick_d_i && (hr_i == tgt_q.hr) && (min_i == tgt_q.min) && (sec_i == '0);

  always_comb begin
    state_d    = state_q;
    al_hr_d    = al_hr_q;
    al_min_d   = al_min_q;
    en_d       = en_q;
    tgt_d      = tgt_q;
    ring_cnt_d = ring_cnt_q;
    if (wr_i) begin
      state_d  = IDLE;
      al_hr_d  = wr_hr_i;
      al_min_d = wr_min_i;
      en_d     = wr_en_i;
    end else begin
      case (state_q)
        IDLE: begin
          if (alarm_hit) begin
            state_d    = RINGING;
            ring_cnt_d = '0;
          end
        end
        RINGING: begin
          // dismiss wins over snooze, both win over the timeout
          if (clear_i) begin
            state_d = IDLE;
          end else if (snooze_i) begin
            state_d = SNOOZE;
            tgt_d   = add_minutes(hr_i, min_i, SNOOZE_MIN);
          end else if (tick_d_i) begin
            if (ring_cnt_q == 8'(RING_TIMEOUT_SEC - 1)) begin
              state_d = IDLE;
            end else begin
              ring_cnt_d = ring_cnt_q + 8'd1;
            end
          end
        end
        SNOOZE: begin
          if (clear_i) begin
            state_d = IDLE;
          end else if (snooze_hit) begin
            state_d    = RINGING;
            ring_cnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      al_hr_q    <= '0;
      al_min_q   <= '0;
      en_q       <= 1'b0;
      tgt_q      <= '0;
      ring_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      al_hr_q    <= al_hr_d;
      al_min_q   <= al_min_d;
      en_q       <= en_d;
      tgt_q      <= tgt_d;
      ring_cnt_q <= ring_cnt_d;
    end
  end

  assign ringing_o = (state_q == RINGING);

endmodule

// File: rtl/multi_alarm_clock.sv
// 24 h timekeeping with prescaler, 12/24 h display conversion and
// NUM_ALARMS independent alarm channels.
module multi_alarm_clock
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC    = 10,
  parameter int NUM_ALARMS       = 4,
  parameter int SNOOZE_MIN       = 5,
  parameter int RING_TIMEOUT_SEC = 60,
  localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_time,
  input  logic [4:0]            hr_in,
  input  logic [5:0]            min_in,
  input  logic [5:0]            sec_in,
  input  logic                  mode_12h,
  input  logic                  set_alarm,
  input  logic [AW-1:0]         alarm_sel,
  input  logic [4:0]            alarm_hr_in,
  input  logic [5:0]            alarm_min_in,
  input  logic                  alarm_en_in,
  input  logic [NUM_ALARMS-1:0] alarm_clear,
  input  logic [NUM_ALARMS-1:0] snooze,
  output logic [4:0]            hr,
  output logic [5:0]            min,
  output logic [5:0]            sec,
  output logic                  pm,
  output logic [NUM_ALARMS-1:0] alarm_ringing,
  output logic                  alarm_any
);

  localparam int PW = $clog2(TICKS_PER_SEC);

  logic [PW-1:0] pre_q, pre_d;
  logic [4:0]    hr_q, hr_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic          tick_d_q, tick_d_d;
  logic          tick;
  logic          load_ok;
  logic          alarm_wr_ok;

  assign tick    = (pre_q == PW'(TICKS_PER_SEC - 1));
  assign load_ok = set_time && (hr_in <= 5'(HR_MAX)) && (min_in <= 6'(MIN_MAX)) && (sec_in <= 6'(SEC_MAX));
  assign alarm_wr_ok = set_alarm && (alarm_hr_in <= 5'(HR_MAX)) && (alarm_min_in <= 6'(MIN_MAX))
                       && (int'(alarm_sel) < NUM_ALARMS);

  always_comb begin
    pre_d = pre_q;
    hr_d  = hr_q;
    min_d = min_q;
    sec_d = sec_q;
    // a load suppresses this edge's tick so no match is evaluated on loaded time
    tick_d_d = tick && !load_ok;
    if (load_ok) begin
      pre_d = '0;
      hr_d  = hr_in;
      min_d = min_in;
      sec_d = sec_in;
    end else if (tick) begin
      pre_d = '0;
      if (sec_q == 6'(SEC_MAX)) begin
        sec_d = '0;
        if (min_q == 6'(MIN_MAX)) begin
          min_d = '0;
          hr_d  = (hr_q == 5'(HR_MAX)) ? 5'd0 : hr_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end else begin
      pre_d = pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q    <= '0;
      hr_q     <= '0;
      min_q    <= '0;
      sec_q    <= '0;
      tick_d_q <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      hr_q     <= hr_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      tick_d_q <= tick_d_d;
    end
  end

  always_comb begin
    pm = (hr_q >= 5'd12);
    hr = hr_q;
    if (mode_12h) begin
      if (hr_q == 5'd0) begin
        hr = 5'd12;
      end else if (hr_q > 5'd12) begin
        hr = hr_q - 5'd12;
      end
    end
  end

  assign min = min_q;
  assign sec = sec_q;

  for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_ch
    alarm_channel #(
      .SNOOZE_MIN       (SNOOZE_MIN),
      .RING_TIMEOUT_SEC (RING_TIMEOUT_SEC)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_i      (alarm_wr_ok && (alarm_sel == AW'(gi))),
      .wr_hr_i   (alarm_hr_in),
      .wr_min_i  (alarm_min_in),
      .wr_en_i   (alarm_en_in),
      .clear_i   (alarm_clear[gi]),
      .snooze_i  (snooze[gi]),
      .tick_d_i  (tick_d_q),
      .hr_i      (hr_q),
      .min_i     (min_q),
      .sec_i     (sec_q),
      .ringing_o (alarm_ringing[gi])
    );
  end

  assign alarm_any = |alarm_ringing;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Randomised and directed bench for multi_alarm_clock against a seconds-of-day
// reference model.
module tb_multi_alarm_clock;

  localparam int TPS = 10;
  localparam int NA  = 4;
  localparam int SN  = 5;
  localparam int RT  = 60;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          set_time = 1'b0;
  logic [4:0]    hr_in = '0;
  logic [5:0]    min_in = '0;
  logic [5:0]    sec_in = '0;
  logic          mode_12h = 1'b0;
  logic          set_alarm = 1'b0;
  logic [1:0]    alarm_sel = '0;
  logic [4:0]    alarm_hr_in = '0;
  logic [5:0]    alarm_min_in = '0;
  logic          alarm_en_in = 1'b0;
  logic [NA-1:0] alarm_clear = '0;
  logic [NA-1:0] snooze = '0;
  logic [4:0]    hr;
  logic [5:0]    min;
  logic [5:0]    sec;
  logic          pm;
  logic [NA-1:0] alarm_ringing;
  logic          alarm_any;
  logic [22:0]   obs;

  multi_alarm_clock #(
    .TICKS_PER_SEC(TPS), .NUM_ALARMS(NA), .SNOOZE_MIN(SN), .RING_TIMEOUT_SEC(RT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .set_time(set_time), .hr_in(hr_in), .min_in(min_in),
    .sec_in(sec_in), .mode_12h(mode_12h), .set_alarm(set_alarm), .alarm_sel(alarm_sel),
    .alarm_hr_in(alarm_hr_in), .alarm_min_in(alarm_min_in), .alarm_en_in(alarm_en_in),
    .alarm_clear(alarm_clear), .snooze(snooze), .hr(hr), .min(min), .sec(sec), .pm(pm),
    .alarm_ringing(alarm_ringing), .alarm_any(alarm_any)
  );

  always #5 clk = ~clk;

  assign obs = {hr, min, sec, pm, alarm_ringing, alarm_any};

  int passed = 0;
  int total  = 0;

  // reference model: time as seconds of day, alarms as minutes of day
  int m_sod, m_pre;
  bit m_tickd;
  bit m_ring[NA];
  bit m_snz[NA];
  bit m_en[NA];
  int m_left[NA];
  int m_tgt[NA];
  int m_al[NA];

  task automatic model_reset();
    m_sod = 0; m_pre = 0; m_tickd = 0;
    for (int i = 0; i < NA; i++) begin
      m_ring[i] = 0; m_snz[i] = 0; m_en[i] = 0; m_left[i] = 0; m_tgt[i] = 0; m_al[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit wr;
    for (int i = 0; i < NA; i++) begin
      wr = set_alarm && (alarm_hr_in < 24) && (alarm_min_in < 60) && (int'(alarm_sel) == i);
      if (wr) begin
        m_ring[i] = 0; m_snz[i] = 0; m_en[i] = alarm_en_in;
        m_al[i] = int'(alarm_hr_in) * 60 + int'(alarm_min_in);
      end else if (m_ring[i]) begin
        if (alarm_clear[i]) m_ring[i] = 0;
        else if (snooze[i]) begin
          m_ring[i] = 0; m_snz[i] = 1; m_tgt[i] = (m_sod / 60 + SN) % 1440;
        end else if (m_tickd) begin
          m_left[i]--;
          if (m_left[i] == 0) m_ring[i] = 0;
        end
      end else if (m_snz[i]) begin
        if (alarm_clear[i]) m_snz[i] = 0;
        else if (m_tickd && m_sod == m_tgt[i] * 60) begin
          m_snz[i] = 0; m_ring[i] = 1; m_left[i] = RT;
        end
      end else if (m_en[i] && m_tickd && m_sod == m_al[i] * 60) begin
        m_ring[i] = 1; m_left[i] = RT;
      end
    end
    if (set_time && hr_in < 24 && min_in < 60 && sec_in < 60) begin
      m_sod = int'(hr_in) * 3600 + int'(min_in) * 60 + int'(sec_in);
      m_pre = 0; m_tickd = 0;
    end else if (m_pre == TPS - 1) begin
      m_pre = 0; m_sod = (m_sod + 1) % 86400; m_tickd = 1;
    end else begin
      m_pre++; m_tickd = 0;
    end
  endtask

  function automatic logic [22:0] exp_vec();
    int h, dh;
    logic [NA-1:0] rv;
    h  = m_sod / 3600;
    dh = mode_12h ? ((h % 12 == 0) ? 12 : h % 12) : h;
    for (int i = 0; i < NA; i++) rv[i] = m_ring[i];
    return {5'(dh), 6'((m_sod / 60) % 60), 6'(m_sod % 60), (h >= 12), rv, |rv};
  endfunction

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic pulse_set_time(input int h, input int m, input int s);
    hr_in = 5'(h); min_in = 6'(m); sec_in = 6'(s); set_time = 1'b1;
    cycle();
    set_time = 1'b0;
  endtask

  task automatic pulse_set_alarm(input int ch, input int h, input int m, input bit en);
    alarm_sel = 2'(ch); alarm_hr_in = 5'(h); alarm_min_in = 6'(m); alarm_en_in = en;
    set_alarm = 1'b1;
    cycle();
    set_alarm = 1'b0;
  endtask

  task automatic pulse_clear(input logic [NA-1:0] mask);
    alarm_clear = mask;
    cycle();
    alarm_clear = '0;
  endtask

  task automatic pulse_snooze(input logic [NA-1:0] mask);
    snooze = mask;
    cycle();
    snooze = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    total++;
    if (obs !== 23'd0) $display("FAIL reset_24h: got %h expected %h", obs, 23'd0);
    else passed++;
    mode_12h = 1'b1;
    #1;
    total++;
    if (hr !== 5'd12 || pm !== 1'b0) $display("FAIL reset_12h: got hr=%0d pm=%0b expected hr=12 pm=0", hr, pm);
    else passed++;
    mode_12h = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_timekeeping();
    run(600);
    total++;
    if (hr !== 5'd0 || min !== 6'd1 || sec !== 6'd0)
      $display("FAIL run_600: got %0d:%0d:%0d expected 0:1:0", hr, min, sec);
    else passed++;
    pulse_set_time(23, 59, 59);
    run(10);
    total++;
    if (obs !== exp_vec() || {hr, min, sec, pm} !== 18'd0)
      $display("FAIL midnight_wrap: got %h expected %h", obs, exp_vec());
    else passed++;
    $display("test_timekeeping done time=%0d:%0d:%0d", hr, min, sec);
  endtask

  task automatic test_alarm_basic();
    pulse_set_alarm(0, 7, 30, 1'b1);
    pulse_set_time(7, 29, 59);
    run(10);
    total++;
    if (alarm_ringing !== 4'b0000) $display("FAIL ring_early: got %b expected 0000", alarm_ringing);
    else passed++;
    cycle();
    total++;
    if (alarm_ringing !== 4'b0001 || obs !== exp_vec())
      $display("FAIL ring_ch0: got %b expected 0001 (vec %h vs %h)", alarm_ringing, obs, exp_vec());
    else passed++;
    pulse_clear(4'b0001);
    pulse_set_time(7, 30, 0);
    run(12);
    total++;
    if (alarm_ringing !== 4'b0000 || obs !== exp_vec())
      $display("FAIL no_ring_after_set_time: got %b expected 0000", alarm_ringing);
    else passed++;
    $display("test_alarm_basic done");
  endtask

  task automatic test_snooze();
    pulse_set_alarm(1, 6, 58, 1'b1);
    pulse_set_time(6, 57, 59);
    run(11);
    total++;
    if (alarm_ringing !== 4'b0010) $display("FAIL ring_ch1: got %b expected 0010", alarm_ringing);
    else passed++;
    pulse_snooze(4'b0010);
    total++;
    if (alarm_ringing !== 4'b0000 || obs !== exp_vec()) $display("FAIL snooze_stop: got %b expected 0000", alarm_ringing);
    else passed++;
    pulse_set_time(7, 2, 59);
    run(10);
    total++;
    if (alarm_ringing !== 4'b0000) $display("FAIL snooze_early: got %b expected 0000", alarm_ringing);
    else passed++;
    cycle();
    total++;
    if (alarm_ringing !== 4'b0010 || obs !== exp_vec()) $display("FAIL snooze_ring: got %b expected 0010", alarm_ringing);
    else passed++;
    pulse_clear(4'b0010);
    total++;
    if (alarm_ringing !== 4'b0000) $display("FAIL snooze_clear: got %b expected 0000", alarm_ringing);
    else passed++;
    $display("test_snooze done");
  endtask

  task automatic test_timeout();
    pulse_set_time(7, 29, 59);
    run(11);
    for (int k = 1; k <= RT * TPS; k++) begin
      cycle();
      total++;
      if (obs !== exp_vec()) $display("FAIL timeout_track k=%0d: got %h expected %h", k, obs, exp_vec());
      else passed++;
      if (k == RT * TPS - 1) begin
        total++;
        if (alarm_ringing !== 4'b0001) $display("FAIL timeout_last: got %b expected 0001", alarm_ringing);
        else passed++;
      end
    end
    total++;
    if (alarm_ringing !== 4'b0000) $display("FAIL timeout_stop: got %b expected 0000", alarm_ringing);
    else passed++;
    pulse_set_time(7, 29, 59);
    run(11);
    alarm_clear = 4'b0001; snooze = 4'b0001;
    cycle();
    alarm_clear = '0; snooze = '0;
    total++;
    if (alarm_ringing !== 4'b0000) $display("FAIL clear_snooze_same: got %b expected 0000", alarm_ringing);
    else passed++;
    pulse_set_time(7, 34, 59);
    run(11);
    total++;
    if (alarm_ringing !== 4'b0000 || obs !== exp_vec())
      $display("FAIL clear_beats_snooze: got %b expected 0000", alarm_ringing);
    else passed++;
    $display("test_timeout done");
  endtask

  task automatic test_multi();
    pulse_set_alarm(2, 12, 0, 1'b1);
    pulse_set_alarm(3, 12, 0, 1'b1);
    pulse_set_time(11, 59, 59);
    run(11);
    total++;
    if (alarm_ringing !== 4'b1100 || alarm_any !== 1'b1)
      $display("FAIL two_ring: got %b any=%0b expected 1100 any=1", alarm_ringing, alarm_any);
    else passed++;
    mode_12h = 1'b1;
    #1;
    total++;
    if (hr !== 5'd12 || pm !== 1'b1) $display("FAIL noon_12h: got hr=%0d pm=%0b expected 12/1", hr, pm);
    else passed++;
    pulse_clear(4'b1100);
    pulse_set_time(0, 15, 0);
    total++;
    if (hr !== 5'd12 || pm !== 1'b0 || obs !== exp_vec())
      $display("FAIL midnight_12h: got hr=%0d pm=%0b expected 12/0", hr, pm);
    else passed++;
    pulse_set_time(13, 20, 0);
    total++;
    if (hr !== 5'd1 || pm !== 1'b1 || obs !== exp_vec())
      $display("FAIL pm_12h: got hr=%0d pm=%0b expected 1/1", hr, pm);
    else passed++;
    mode_12h = 1'b0;
    $display("test_multi done");
  endtask

  task automatic test_invalid();
    pulse_set_time(24, 0, 0);
    total++;
    if (hr !== 5'd13 || obs !== exp_vec()) $display("FAIL bad_hour_load: got hr=%0d expected 13", hr);
    else passed++;
    pulse_set_time(10, 60, 0);
    total++;
    if (obs !== exp_vec()) $display("FAIL bad_min_load: got %h expected %h", obs, exp_vec());
    else passed++;
    pulse_set_time(11, 59, 59);
    run(11);
    pulse_set_alarm(2, 5, 0, 1'b1);
    total++;
    if (alarm_ringing !== 4'b1000) $display("FAIL set_alarm_ringing: got %b expected 1000", alarm_ringing);
    else passed++;
    pulse_set_alarm(3, 12, 60, 1'b0);
    total++;
    if (alarm_ringing !== 4'b1000 || obs !== exp_vec())
      $display("FAIL bad_alarm_write: got %b expected 1000", alarm_ringing);
    else passed++;
    pulse_clear(4'b1111);
    $display("test_invalid done");
  endtask

  task automatic test_random();
    int mm;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        hr_in = 5'($urandom_range(0, 24)); min_in = 6'($urandom_range(0, 60));
        sec_in = 6'($urandom_range(55, 60)); set_time = 1'b1;
      end
      if ($urandom_range(0, 99) == 0) begin
        mm = (m_sod / 60) % 60 + int'($urandom_range(0, 1));
        alarm_sel = 2'($urandom_range(0, NA - 1)); alarm_hr_in = 5'(m_sod / 3600);
        alarm_min_in = 6'(mm); alarm_en_in = ($urandom_range(0, 3) != 0); set_alarm = 1'b1;
      end
      if ($urandom_range(0, 299) == 0) alarm_clear = NA'($urandom);
      if ($urandom_range(0, 99) == 0) snooze = NA'($urandom);
      if ($urandom_range(0, 499) == 0) mode_12h = ~mode_12h;
      cycle();
      set_time = 1'b0; set_alarm = 1'b0; alarm_clear = '0; snooze = '0;
      #1;
      total++;
      if (obs !== exp_vec()) $display("FAIL random k=%0d: got %h expected %h", k, obs, exp_vec());
      else passed++;
    end
    mode_12h = 1'b0;
    @(negedge clk);
    $display("test_random done");
  endtask

  task automatic test_async_reset();
    pulse_set_alarm(0, 7, 30, 1'b1);
    pulse_set_time(7, 29, 59);
    run(11);
    total++;
    if (alarm_ringing[0] !== 1'b1 || obs !== exp_vec())
      $display("FAIL pre_reset_ring: got %b expected ch0 ringing", alarm_ringing);
    else passed++;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (obs !== 23'd0) $display("FAIL async_reset: got %h expected %h", obs, 23'd0);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    run(15);
    total++;
    if (obs !== exp_vec()) $display("FAIL post_reset: got %h expected %h", obs, exp_vec());
    else passed++;
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_timekeeping();
    test_alarm_basic();
    test_snooze();
    test_timeout();
    test_multi();
    test_invalid();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multi_alarm_clock.md
Name: multi_alarm_clock

Overview:
Parametrised successor of the single-alarm 24 h clock. Keeps the prescaled seconds/minutes/hours timekeeping and adds NUM_ALARMS independent alarm channels, each with snooze and ring auto-timeout, plus 12 h/24 h display mode. Sits at the top of the clock datapath, feeding display and buzzer logic.

Parameters:
TICKS_PER_SEC, 10, clk cycles per second (>=2)
NUM_ALARMS, 4, alarm channel count (1..16)
SNOOZE_MIN, 5, snooze length in minutes (1..59)
RING_TIMEOUT_SEC, 60, seconds an alarm rings before auto-stop (1..255)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
set_time  in  1  load hr_in/min_in/sec_in (24 h format)
hr_in  in  5  hour 0..23
min_in  in  6  minute 0..59
sec_in  in  6  second 0..59
mode_12h  in  1  1 = 12 h display on hr/pm
set_alarm  in  1  write alarm channel alarm_sel
alarm_sel  in  AW  channel index, AW = max(1,$clog2(NUM_ALARMS))
alarm_hr_in  in  5  alarm hour 0..23
alarm_min_in  in  6  alarm minute 0..59
alarm_en_in  in  1  enable written with set_alarm
alarm_clear  in  NUM_ALARMS  per-channel dismiss
snooze  in  NUM_ALARMS  per-channel snooze request
hr  out  5  display hour (0..23, or 1..12 in 12 h mode)
min  out  6  minute
sec  out  6  second
pm  out  1  1 when internal hour >= 12 (valid in both modes)
alarm_ringing  out  NUM_ALARMS  per-channel ringing
alarm_any  out  1  OR of alarm_ringing

Behaviour:
- Reset: internal time 00:00:00, prescaler 0, all channels disabled, alarm time 00:00, state IDLE. Outputs: min=0, sec=0, pm=0, alarm_ringing=0, alarm_any=0; hr=0 (24 h) or 12 (12 h).
- Prescaler counts 0..TICKS_PER_SEC-1; tick asserted on the cycle count==TICKS_PER_SEC-1; time increments on that edge. sec 59->0 carries to min; min 59->0 carries to hr; 23:59:59 -> 00:00:00.
- set_time: loads time and clears prescaler at the same edge; takes priority over tick. Load ignored entirely if any field is out of range.
- Display: hr/pm combinational from internal hour: 0->12 AM, 1..11 AM, 12->12 PM, 13..23->1..11 PM. Mode switch does not affect timekeeping.
- Per channel FSM IDLE/RINGING/SNOOZE; match is evaluated one cycle after a tick (tick_d), never after set_time.
- IDLE->RINGING: enabled && tick_d && time == alarm_hr:alarm_min:00.
- RINGING: ring counter counts ticks; after RING_TIMEOUT_SEC ticks ->IDLE. alarm_clear[i] ->IDLE. snooze[i] ->SNOOZE, target = current hr:min + SNOOZE_MIN, mod 24 h.
- SNOOZE: tick_d && time == target:00 ->RINGING (ring counter restarted). alarm_clear[i] ->IDLE. snooze[i] ignored.
- Simultaneous: alarm_clear beats snooze; clear/snooze beat a same-cycle match. Clear in IDLE is a no-op.
- set_alarm to channel i: writes hr/min/en, forces channel i to IDLE. Write ignored if alarm_hr_in/alarm_min_in out of range or alarm_sel >= NUM_ALARMS.
- Disabled channel never leaves IDLE. alarm_ringing[i] = (state==RINGING), registered; asserts one cycle after tick_d.
- Asynchronous reset mid-ring returns to reset values immediately.

Decomposition:
- clock_pkg: HR_MAX=23, MIN_MAX=59, SEC_MAX=59, alarm_state_t enum {IDLE,RINGING,SNOOZE}, helper function add_minutes(hr,min,n) with 24 h wrap.
- Sub-module alarm_channel (alarm registers, snooze target, ring counter, FSM), generated NUM_ALARMS times; timekeeping stays in the top level.

Test Plan:
- Reset, run 10*60 cycles (TPS=10) -> min=1, sec=0; set_time 23:59:59, 10 cycles -> 00:00:00, pm=0.
- Alarm0 07:30 enabled, set_time 07:29:59, one second -> alarm_ringing=0001 one cycle after tick_d; set_time directly to 07:30:00 -> no ring.
- Ring alarm1 at 06:58, snooze -> SNOOZE, target 07:03; at 07:03:00 rings again; clear -> 0.
- Ringing with no action -> auto-stop after exactly 60 seconds (600 ticks of clk/10); snooze+clear same cycle -> IDLE.
- Alarms 2 and 3 both at 12:00 -> alarm_ringing=1100, alarm_any=1; mode_12h=1 at 12:00 -> hr=12, pm=1; at 00:xx -> hr=12, pm=0; at 13:xx -> hr=1.
- set_time hr_in=24 -> ignored; set_alarm to ringing channel -> ringing drops next cycle; rst_n low mid-ring -> all outputs at reset values.
